// File: rtl/mul8_dot_acc.sv
// mul8_dot_acc: sums a programmable number of approximate-multiplier products into one held result.
// Optional multiplier error monitor (err_sum/err_max) enabled by defining MUL8_DOT_ACC_ERR_MON_EN.
module mul8_dot_acc #(
    parameter int unsigned PROD_W = 16,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_a,
    input  logic [7:0]        in_b,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [LEN_W-1:0]  out_count,
    output logic              out_ovf
`ifdef MUL8_DOT_ACC_ERR_MON_EN
    ,
    output logic [ACC_W-1:0]  err_sum,
    output logic [15:0]       err_max
`endif
);
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             beat, load_c, add_c, clr_c;
    logic [SUM_W-1:0] acc_sum;
    logic [LEN_W-1:0] count_inc, len_eff;

    // Ready is a pure state decode, forced low while reset is asserted.
    assign in_ready  = rst_n && (state_q != ST_HOLD);
    assign beat      = in_valid && in_ready;
    assign load_c    = beat && (state_q == ST_IDLE);
    assign add_c     = beat && (state_q == ST_ACCUM);
    assign clr_c     = (state_q == ST_HOLD) && out_ready;
    assign acc_sum   = {1'b0, acc_q} + SUM_W'(in_prod);
    assign count_inc = count_q + LEN_W'(1);
    assign len_eff   = (cfg_len == '0) ? LEN_W'(1) : cfg_len;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (load_c) begin
                    len_d   = len_eff;
                    acc_d   = ACC_W'(in_prod);
                    count_d = LEN_W'(1);
                    ovf_d   = 1'b0;
                    state_d = (len_eff == LEN_W'(1)) ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (add_c) begin
                    acc_d   = acc_sum[ACC_W-1:0];
                    ovf_d   = ovf_q | acc_sum[ACC_W];
                    count_d = count_inc;
                    if (count_inc == len_q) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (clr_c) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = acc_q;
    assign out_count = count_q;
    assign out_ovf   = ovf_q;

`ifdef MUL8_DOT_ACC_ERR_MON_EN
    logic [15:0]        exact_c, err_c;
    logic signed [16:0] diff_c;
    logic [SUM_W-1:0]   err_add_c;
    logic [ACC_W-1:0]   err_sum_q, err_sum_d;
    logic [15:0]        err_max_q, err_max_d;

    // |exact - approx| in 17-bit signed; the magnitude always fits 16 bits.
    assign exact_c   = 16'(in_a) * 16'(in_b);
    assign diff_c    = $signed({1'b0, exact_c}) - $signed({1'b0, 16'(in_prod)});
    assign err_c     = diff_c[16] ? 16'(-diff_c) : diff_c[15:0];
    assign err_add_c = {1'b0, err_sum_q} + SUM_W'(err_c);

    always_comb begin
        err_sum_d = err_sum_q;
        err_max_d = err_max_q;
        if (load_c) begin
            err_sum_d = ACC_W'(err_c);
            err_max_d = err_c;
        end else if (add_c) begin
            err_sum_d = err_add_c[ACC_W] ? '1 : err_add_c[ACC_W-1:0];
            err_max_d = (err_c > err_max_q) ? err_c : err_max_q;
        end else if (clr_c) begin
            err_sum_d = '0;
            err_max_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sum_q <= '0;
            err_max_q <= '0;
        end else begin
            err_sum_q <= err_sum_d;
            err_max_q <= err_max_d;
        end
    end

    assign err_sum = err_sum_q;
    assign err_max = err_max_q;
`else
    logic unused_err_mon;
    assign unused_err_mon = ^{in_a, in_b};
`endif
endmodule
